pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//   Hazard controller for the 5-stage ARM pipeline (IF, ID, EX, MEM, WB).
//   It detects load-use hazards and inserts STALL_CYCLES bubbles. During a bubble it
//   freezes the PC and IF/ID registers and drives the CU mux NOP select.
//   It selects operand forwarding sources for PA/PB/PD, flushes IF/ID on a taken
//   branch, and keeps saturating stall and flush counters for performance checks.
// PARAMETERS
//   STALL_CYCLES  1   bubbles inserted per load-use hazard (1..15)
//   CNT_W         16  width of stall_count / flush_count
// PORTS
//   Clk             in   1      pipeline clock, rising edge
//   Clr             in   1      asynchronous, active-low reset
//   ID_Rn           in   4      ID-stage source register Rn (I19_16)
//   ID_Rm           in   4      ID-stage source register Rm (I3_0)
//   ID_Rd           in   4      ID-stage store-data register Rd (I15_12)
//   ID_use_Rn       in   1      ID instruction reads Rn
//   ID_use_Rm       in   1      ID instruction reads Rm
//   ID_use_Rd       in   1      ID instruction reads Rd (store)
//   ID_branch_taken in   1      branch/BL in ID resolved taken
//   EX_RD           in   4      EX destination register
//   EX_RF_enable    in   1      EX instruction writes the register file
//   EX_load_instr   in   1      EX instruction is LDR/LDRB
//   MEM_RD          in   4      MEM destination register
//   MEM_RF_enable   in   1      MEM instruction writes the register file
//   WB_RD           in   4      WB destination register
//   WB_RF_enable    in   1      WB instruction writes the register file
//   PC_LE           out  1      PC load enable
//   IFID_LE         out  1      IF/ID load enable
//   CU_MUX_E        out  1      1 = CU mux drives NOP controls into ID/EX
//   IFID_flush      out  1      1 = IF/ID captures all-zero (NOP) at next edge
//   fwd_A           out  2      PA source: 00 RF, 01 EX, 10 MEM, 11 WB
//   fwd_B           out  2      PB source, same encoding
//   fwd_D           out  2      PD source, same encoding
//   stall_count     out  CNT_W  total bubble cycles, saturating
//   flush_count     out  CNT_W  total flush cycles, saturating
// BEHAVIOUR
//   Reset (Clr=0, async):
//     - state=RUN, stall counter=0, stall_count=0, flush_count=0.
//     - Outputs forced while Clr=0: PC_LE=0, IFID_LE=0, CU_MUX_E=1, IFID_flush=0, fwd_*=00.
//   Output timing:
//     - Control and forwarding outputs are combinational (state + inputs), valid in the same cycle.
//     - The counters are registered.
//   Forwarding, per operand X in {Rn->A, Rm->B, Rd->D}:
//     - Select EX if use & EX_RF_enable & !EX_load_instr & EX_RD==X.
//     - Otherwise MEM if MEM_RF_enable & MEM_RD==X, otherwise WB if WB_RF_enable & WB_RD==X,
//       otherwise 00.
//     - Priority EX > MEM > WB.
//     - X==4'hF (R15) always gives 00.
//   Load-use hazard:
//     - hz = EX_load_instr & EX_RF_enable & any(use_X & X==EX_RD & X!=15).
//   FSM states: RUN, STALL.
//     RUN, hz=1:
//       - Outputs PC_LE=0, IFID_LE=0, CU_MUX_E=1, IFID_flush=0. This is bubble 1.
//       - If STALL_CYCLES==1, stay in RUN.
//       - Otherwise go to STALL and load cnt=STALL_CYCLES-1.
//     RUN, hz=0, ID_branch_taken=1: PC_LE=1, IFID_LE=1, CU_MUX_E=0, IFID_flush=1.
//     RUN, no event: PC_LE=1, IFID_LE=1, CU_MUX_E=0, IFID_flush=0.
//     STALL:
//       - Outputs as for a hazard bubble.
//       - cnt decrements each edge. Return to RUN at the edge where cnt==1.
//       - ID_branch_taken is ignored; the held branch re-asserts after the stall.
//     Simultaneous hz and branch_taken: the stall wins and no flush is issued that cycle.
//   Counters:
//     - stall_count +1 on every edge where a bubble was output.
//     - flush_count +1 on every edge where IFID_flush=1.
//     - Both saturate at all-ones.
//   Reset mid-stall: returns immediately to RUN; the pending bubbles are discarded.
// TESTING
//   - EX: ADD R3 (RF_en, not load); ID uses Rn=3 -> fwd_A=01; PC_LE=1; no stall.
//   - EX:R3, MEM:R3, WB:R3 all writing; ID Rm=3 -> fwd_B=01.
//     Drop EX_RF_enable -> fwd_B=10.
//   - EX: LDR R5; ID uses Rm=5; STALL_CYCLES=1 -> exactly 1 cycle of PC_LE=0, CU_MUX_E=1.
//     Then MEM:R5 -> fwd_B=10; stall_count=1.
//   - STALL_CYCLES=3, same load-use -> 3 consecutive bubble cycles.
//     branch_taken held high throughout -> no flush until RUN; flush_count +1 after.
//   - ID Rn=15 with EX_RD=15 writing, load or not -> fwd_A=00; no stall.
//   - Drive Clr=0 during the 2nd of 3 stall cycles -> outputs go to reset values at once.
//     After release, state=RUN and counters=0.
//   - Force stall_count to near all-ones via a long stall run -> count holds at all-ones.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: load-use stall FSM, operand forwarding
// selects for PA/PB/PD, IF/ID flush on taken branch, saturating stall/flush counters.

module pipeline_hazard_fwd_lane (
  input  logic [3:0] src,
  input  logic       use_src,
  input  logic [3:0] EX_RD,
  input  logic       EX_RF_enable,
  input  logic       EX_load_instr,
  input  logic [3:0] MEM_RD,
  input  logic       MEM_RF_enable,
  input  logic [3:0] WB_RD,
  input  logic       WB_RF_enable,
  output logic [1:0] fwd,
  output logic       ld_hit
);
  logic is_pc;
  assign is_pc = (src == 4'hF);

  // R15 is read from the PC path, never forwarded
  always_comb begin
    fwd = 2'b00;
    if (!is_pc) begin
      if (use_src && EX_RF_enable && !EX_load_instr && EX_RD == src) fwd = 2'b01;
      else if (MEM_RF_enable && MEM_RD == src)                      fwd = 2'b10;
      else if (WB_RF_enable && WB_RD == src)                        fwd = 2'b11;
    end
  end

  assign ld_hit = use_src && !is_pc && (src == EX_RD) && EX_load_instr && EX_RF_enable;
endmodule

module pipeline_hazard_ctrl #(
  parameter int STALL_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic [3:0]       ID_Rn,
  input  logic [3:0]       ID_Rm,
  input  logic [3:0]       ID_Rd,
  input  logic             ID_use_Rn,
  input  logic             ID_use_Rm,
  input  logic             ID_use_Rd,
  input  logic             ID_branch_taken,
  input  logic [3:0]       EX_RD,
  input  logic             EX_RF_enable,
  input  logic             EX_load_instr,
  input  logic [3:0]       MEM_RD,
  input  logic             MEM_RF_enable,
  input  logic [3:0]       WB_RD,
  input  logic             WB_RF_enable,
  output logic             PC_LE,
  output logic             IFID_LE,
  output logic             CU_MUX_E,
  output logic             IFID_flush,
  output logic [1:0]       fwd_A,
  output logic [1:0]       fwd_B,
  output logic [1:0]       fwd_D,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);
  localparam int         NUM_OPS  = 3;
  localparam logic [3:0] CNT_INIT = 4'(STALL_CYCLES - 1);

  typedef enum logic {RUN, STALL} state_t;

  logic [NUM_OPS-1:0][3:0] op_reg;
  logic [NUM_OPS-1:0]      op_use;
  logic [NUM_OPS-1:0][1:0] op_fwd;
  logic [NUM_OPS-1:0]      op_ld_hit;

  assign op_reg = {ID_Rd, ID_Rm, ID_Rn};
  assign op_use = {ID_use_Rd, ID_use_Rm, ID_use_Rn};

  genvar g;
  generate
    for (g = 0; g < NUM_OPS; g++) begin : g_op
      pipeline_hazard_fwd_lane u_lane (
        .src          (op_reg[g]),
        .use_src      (op_use[g]),
        .EX_RD        (EX_RD),
        .EX_RF_enable (EX_RF_enable),
        .EX_load_instr(EX_load_instr),
        .MEM_RD       (MEM_RD),
        .MEM_RF_enable(MEM_RF_enable),
        .WB_RD        (WB_RD),
        .WB_RF_enable (WB_RF_enable),
        .fwd          (op_fwd[g]),
        .ld_hit       (op_ld_hit[g])
      );
    end
  endgenerate

  logic       hz;
  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       bubble, flush;

  assign hz = |op_ld_hit;

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bubble  = 1'b0;
    flush   = 1'b0;
    case (state_q)
      RUN: begin
        if (hz) begin
          bubble = 1'b1;
          if (STALL_CYCLES > 1) begin
            state_d = STALL;
            cnt_d   = CNT_INIT;
          end
        end else if (ID_branch_taken) begin
          flush = 1'b1;
        end
      end
      STALL: begin
        // branch is held in ID and re-evaluated once the stall drains
        bubble = 1'b1;
        cnt_d  = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  assign PC_LE      = Clr & ~bubble;
  assign IFID_LE    = Clr & ~bubble;
  assign CU_MUX_E   = ~Clr | bubble;
  assign IFID_flush = Clr & flush;
  assign fwd_A      = Clr ? op_fwd[0] : 2'b00;
  assign fwd_B      = Clr ? op_fwd[1] : 2'b00;
  assign fwd_D      = Clr ? op_fwd[2] : 2'b00;

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (bubble && stall_count != '1) stall_count <= stall_count + 1'b1;
      if (flush  && flush_count != '1) flush_count <= flush_count + 1'b1;
    end
  end
endmodule
